// File: rtl/gcd_datapath.sv
// GCD datapath: X/Y operand registers with subtract-and-reload paths,
// comparison flags for the controller, a result register with a validity
// flag, a saturating subtract-step counter and a sticky zero-operand flag.
module gcd_datapath #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         x_ld,
    input  logic         y_ld,
    input  logic         x_sel,
    input  logic         y_sel,
    input  logic         d_o_ld,
    output logic         x_neq_y,
    output logic         x_lt_y,
    output logic [W-1:0] d_o,
    output logic         d_o_vld,
    output logic [4:0]   iter_cnt,
    output logic         zero_err
);

    localparam logic [4:0] CNT_MAX  = 5'd31;
    localparam logic [4:0] CNT_ZERO = 5'd0;

    // Step counter increment that sticks at its ceiling instead of wrapping.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return v + 5'd1;
        end
    endfunction

    // True when an operand value is all zeros.
    function automatic logic is_zero(input logic [W-1:0] v);
        return (v == {W{1'b0}});
    endfunction

    logic [W-1:0] x_r;
    logic [W-1:0] y_r;
    logic [W-1:0] d_o_r;
    logic         d_o_vld_r;
    logic [4:0]   iter_cnt_r;
    logic         zero_err_r;

    logic [W-1:0] x_diff_s;
    logic [W-1:0] y_diff_s;
    logic [W-1:0] x_nxt_s;
    logic [W-1:0] y_nxt_s;
    logic         x_op_ld_s;
    logic         y_op_ld_s;
    logic         op_ld_s;
    logic         sub_step_s;
    logic         zero_hit_s;
    logic [4:0]   iter_nxt_s;
    logic         vld_nxt_s;
    logic         zero_nxt_s;

    // Both differences come from the current register contents, so a
    // simultaneous X and Y subtract sees the pre-edge pair (wraps mod 2^W).
    always_comb begin
        x_diff_s = x_r - y_r;
        y_diff_s = y_r - x_r;
    end

    // Classify this cycle's enables: external operand load vs subtract step.
    always_comb begin
        x_op_ld_s  = x_ld & ~x_sel;
        y_op_ld_s  = y_ld & ~y_sel;
        op_ld_s    = x_op_ld_s | y_op_ld_s;
        sub_step_s = (x_ld & x_sel) | (y_ld & y_sel);
        zero_hit_s = (x_op_ld_s & is_zero(x_i)) | (y_op_ld_s & is_zero(y_i));
    end

    // Next X/Y register values from the source selects.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (x_ld) begin
            if (x_sel) begin
                x_nxt_s = x_diff_s;
            end else begin
                x_nxt_s = x_i;
            end
        end else begin
            x_nxt_s = x_r;
        end
        if (y_ld) begin
            if (y_sel) begin
                y_nxt_s = y_diff_s;
            end else begin
                y_nxt_s = y_i;
            end
        end else begin
            y_nxt_s = y_r;
        end
    end

    // Status next-state: operand load restarts the count, a result load
    // marks the result valid even when operands reload on the same edge.
    always_comb begin
        iter_nxt_s = iter_cnt_r;
        vld_nxt_s  = d_o_vld_r;
        zero_nxt_s = zero_err_r;
        if (op_ld_s) begin
            iter_nxt_s = CNT_ZERO;
        end else if (sub_step_s) begin
            iter_nxt_s = sat_inc(iter_cnt_r);
        end else begin
            iter_nxt_s = iter_cnt_r;
        end
        if (d_o_ld) begin
            vld_nxt_s = 1'b1;
        end else if (op_ld_s) begin
            vld_nxt_s = 1'b0;
        end else begin
            vld_nxt_s = d_o_vld_r;
        end
        if (op_ld_s) begin
            zero_nxt_s = zero_hit_s;
        end else begin
            zero_nxt_s = zero_err_r;
        end
    end

    // Operand registers; reset clears them immediately, ignoring enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r <= {W{1'b0}};
            y_r <= {W{1'b0}};
        end else begin
            x_r <= x_nxt_s;
            y_r <= y_nxt_s;
        end
    end

    // Result register captures the pre-edge X value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_o_r <= {W{1'b0}};
        end else if (d_o_ld) begin
            d_o_r <= x_r;
        end else begin
            d_o_r <= d_o_r;
        end
    end

    // Status registers: result-valid, step counter and sticky zero flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_o_vld_r  <= 1'b0;
            iter_cnt_r <= CNT_ZERO;
            zero_err_r <= 1'b0;
        end else begin
            d_o_vld_r  <= vld_nxt_s;
            iter_cnt_r <= iter_nxt_s;
            zero_err_r <= zero_nxt_s;
        end
    end

    // Comparison flags depend on register state only, never on inputs.
    assign x_neq_y  = (x_r != y_r);
    assign x_lt_y   = (x_r < y_r);

    assign d_o      = d_o_r;
    assign d_o_vld  = d_o_vld_r;
    assign iter_cnt = iter_cnt_r;
    assign zero_err = zero_err_r;

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath: an arithmetic reference model is
// compared against every output on every falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_gcd_datapath;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] x_i = 4'd0;
    logic [W-1:0] y_i = 4'd0;
    logic         x_ld = 1'b0;
    logic         y_ld = 1'b0;
    logic         x_sel = 1'b0;
    logic         y_sel = 1'b0;
    logic         d_o_ld = 1'b0;
    logic         x_neq_y;
    logic         x_lt_y;
    logic [W-1:0] d_o;
    logic         d_o_vld;
    logic [4:0]   iter_cnt;
    logic         zero_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state (plain integers)
    int m_x = 0, m_y = 0, m_d = 0, m_vld = 0, m_cnt = 0, m_zero = 0;

    gcd_datapath #(.W(W)) dut (
        .clk(clk), .reset(reset), .x_i(x_i), .y_i(y_i),
        .x_ld(x_ld), .y_ld(y_ld), .x_sel(x_sel), .y_sel(y_sel),
        .d_o_ld(d_o_ld), .x_neq_y(x_neq_y), .x_lt_y(x_lt_y),
        .d_o(d_o), .d_o_vld(d_o_vld), .iter_cnt(iter_cnt),
        .zero_err(zero_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: GCD datapath rules expressed with integer arithmetic.
    always @(posedge clk or posedge reset) begin
        int nx, ny;
        bit op, sub, zhit;
        if (reset) begin
            m_x = 0; m_y = 0; m_d = 0; m_vld = 0; m_cnt = 0; m_zero = 0;
        end else begin
            op   = (x_ld && !x_sel) || (y_ld && !y_sel);
            sub  = (x_ld && x_sel) || (y_ld && y_sel);
            zhit = (x_ld && !x_sel && x_i == 0) || (y_ld && !y_sel && y_i == 0);
            nx = m_x; ny = m_y;
            if (x_ld) nx = x_sel ? (m_x - m_y + 16) % 16 : int'(x_i);
            if (y_ld) ny = y_sel ? (m_y - m_x + 16) % 16 : int'(y_i);
            if (d_o_ld) m_d = m_x;
            if (d_o_ld) m_vld = 1;
            else if (op) m_vld = 0;
            if (op) m_cnt = 0;
            else if (sub && m_cnt < 31) m_cnt = m_cnt + 1;
            if (op) m_zero = zhit ? 1 : 0;
            m_x = nx; m_y = ny;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_x_neq_y", int'(x_neq_y), (m_x != m_y) ? 1 : 0);
        chk("cyc_x_lt_y", int'(x_lt_y), (m_x < m_y) ? 1 : 0);
        chk("cyc_d_o", int'(d_o), m_d);
        chk("cyc_d_o_vld", int'(d_o_vld), m_vld);
        chk("cyc_iter_cnt", int'(iter_cnt), m_cnt);
        chk("cyc_zero_err", int'(zero_err), m_zero);
    end

    // One clock with the given enables; returns #1 after the falling edge
    // with all enables released.
    task automatic cyc(input bit xl, input bit yl, input bit xs, input bit ys,
                       input bit dl, input int xv, input int yv);
        x_ld = xl; y_ld = yl; x_sel = xs; y_sel = ys; d_o_ld = dl;
        x_i = xv[W-1:0]; y_i = yv[W-1:0];
        @(posedge clk);
        @(negedge clk);
        #1;
        x_ld = 1'b0; y_ld = 1'b0; x_sel = 1'b0; y_sel = 1'b0; d_o_ld = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_d_o", int'(d_o), 0);
        chk("rst_iter", int'(iter_cnt), 0);
        @(negedge clk);
        #1 reset = 1'b0;

        // 12 / 8 -> 4
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 8);
        chk("ld12_8_lt", int'(x_lt_y), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("xsub_lt", int'(x_lt_y), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("ysub_neq", int'(x_neq_y), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("g12_8_d_o", int'(d_o), 4);
        chk("g12_8_vld", int'(d_o_vld), 1);
        chk("g12_8_cnt", int'(iter_cnt), 2);
        chk("g12_8_model_x", m_x, 4);

        // equal operands 9 / 9
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 9);
        chk("eq_neq", int'(x_neq_y), 0);
        chk("eq_lt", int'(x_lt_y), 0);
        chk("eq_vld_cleared", int'(d_o_vld), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("eq_d_o", int'(d_o), 9);
        chk("eq_cnt", int'(iter_cnt), 0);

        // simultaneous subtract 3 / 5 -> 14 / 2
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 5);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("sim_cnt", int'(iter_cnt), 1);
        chk("sim_lt", int'(x_lt_y), 0);
        chk("sim_model_x", m_x, 14);
        chk("sim_model_y", m_y, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("sim_d_o", int'(d_o), 14);

        // operand load together with result load: valid set wins
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5, 10);
        chk("setwin_vld", int'(d_o_vld), 1);
        chk("setwin_d_o", int'(d_o), 14);
        chk("setwin_lt", int'(x_lt_y), 1);

        // zero operand, then clean reload
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 7);
        chk("zero_set", int'(zero_err), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("zero_sticky", int'(zero_err), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 4);
        chk("zero_clr", int'(zero_err), 0);
        chk("zero_vld", int'(d_o_vld), 0);
        chk("zero_cnt", int'(iter_cnt), 0);

        // saturation: 40 X-subtract steps
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("sat_cnt", int'(iter_cnt), 31);

        // reset mid-computation, between edges
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 8);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("pre_rst_d_o", int'(d_o), 4);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_d_o", int'(d_o), 0);
        chk("mid_rst_vld", int'(d_o_vld), 0);
        chk("mid_rst_cnt", int'(iter_cnt), 0);
        chk("mid_rst_neq", int'(x_neq_y), 0);
        chk("mid_rst_lt", int'(x_lt_y), 0);
        chk("mid_rst_zero", int'(zero_err), 0);
        // loads ignored while reset is high
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9, 3);
        chk("rst_ignore_neq", int'(x_neq_y), 0);
        chk("rst_ignore_vld", int'(d_o_vld), 0);
        reset = 1'b0;

        // fresh 12 / 8 run
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 8);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("fresh_d_o", int'(d_o), 4);
        chk("fresh_cnt", int'(iter_cnt), 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gcd_datapath.md
GCD_DATAPATH -- requirements
Module: gcd_datapath

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port x_i  input  W  external X operand.
REQ-005 SHALL have port y_i  input  W  external Y operand.
REQ-006 SHALL have port x_ld  input  1  load enable for X register.
REQ-007 SHALL have port y_ld  input  1  load enable for Y register.
REQ-008 SHALL have port x_sel  input  1  X source select: 0 = x_i, 1 = X-Y.
REQ-009 SHALL have port y_sel  input  1  Y source select: 0 = y_i, 1 = Y-X.
REQ-010 SHALL have port d_o_ld  input  1  load enable for result register.
REQ-011 SHALL have port x_neq_y  output  1  X register != Y register.
REQ-012 SHALL have port x_lt_y  output  1  X register < Y register, unsigned.
REQ-013 SHALL have port d_o  output  W  result register.
REQ-014 SHALL have port d_o_vld  output  1  result register holds a result for the current operands.
REQ-015 SHALL have port iter_cnt  output  5  subtract-step count since the last operand load, saturating.
REQ-016 SHALL have port zero_err  output  1  sticky flag: a zero operand was loaded from x_i or y_i.

Function
REQ-017 SHALL be the datapath end of the GCD controller interface: it consumes x_ld/y_ld/x_sel/y_sel/d_o_ld and returns x_neq_y/x_lt_y.
REQ-018 SHALL update X on a rising edge with x_ld=1 from x_i (x_sel=0) or from X-Y (x_sel=1); hold X otherwise.
REQ-019 SHALL update Y on a rising edge with y_ld=1 from y_i (y_sel=0) or from Y-X (y_sel=1); hold Y otherwise.
REQ-020 SHALL compute subtractions modulo 2^W (wrap-around, no flag); underflow is controller misuse and needs no other handling.
REQ-021 SHALL use pre-edge X and Y for both differences when x_ld and y_ld with sel=1 are asserted in the same cycle, e.g. X=3, Y=5 -> X=14, Y=2.
REQ-022 SHALL drive x_neq_y and x_lt_y combinationally from the X and Y registers only, with zero input-to-output paths; flags are valid in the cycle after a load.
REQ-023 SHALL load d_o with the pre-edge X register value on a rising edge with d_o_ld=1 (1-cycle latency); d_o holds otherwise.
REQ-024 SHALL set d_o_vld on a d_o_ld edge.
REQ-025 SHALL clear d_o_vld on any edge loading x_i or y_i (x_ld&!x_sel or y_ld&!y_sel); if d_o_ld is also asserted on that edge, set wins.
REQ-026 SHALL clear iter_cnt to 0 on any operand-load edge (as in REQ-025).
REQ-027 SHALL increment iter_cnt by 1 on an edge with (x_ld&x_sel)|(y_ld&y_sel) and no operand load; a simultaneous X and Y subtract counts as 1.
REQ-028 SHALL saturate iter_cnt at 31.
REQ-029 SHALL apply operand-load priority over increment when both occur on one edge.
REQ-030 SHALL set zero_err on an edge where x_i is loaded and equals 0, or y_i is loaded and equals 0.
REQ-031 SHALL keep zero_err set until the next operand-load edge with both loaded operands nonzero, or until reset.
REQ-032 SHALL not block or alter loads when zero_err is set.

Reset
REQ-033 SHALL, on reset assertion, immediately clear X, Y, d_o, d_o_vld, iter_cnt and zero_err to 0, independent of clk.
REQ-034 SHALL therefore drive x_neq_y=0 and x_lt_y=0 during reset.
REQ-035 SHALL abandon any in-progress computation on mid-operation reset with no residual state.
REQ-036 SHALL ignore all load enables while reset is high.
REQ-037 SHALL accept loads starting from the first rising edge after reset deasserts.

Verification
REQ-038 SHALL pass a bench for operands 12 and 8: load x_i=12, y_i=8, then X-subtract, then Y-subtract, then d_o_ld -> X=4, Y=4, x_neq_y=0, d_o=4, d_o_vld=1, iter_cnt=2.
REQ-039 SHALL pass a bench for equal operands: load 9 and 9 -> x_neq_y=0, x_lt_y=0 next cycle; d_o_ld -> d_o=9, iter_cnt=0.
REQ-040 SHALL pass a bench for simultaneous subtraction: X=3, Y=5, x_ld=y_ld=1, both sel=1 -> X=14, Y=2, iter_cnt +1, x_lt_y=0.
REQ-041 SHALL pass a bench for a zero operand: load x_i=0, y_i=7 -> zero_err=1; reload 6 and 4 -> zero_err=0, d_o_vld=0.
REQ-042 SHALL pass a bench for saturation: 40 consecutive X-subtract cycles -> iter_cnt holds 31.
REQ-043 SHALL pass a bench for reset: assert reset between clock edges mid-computation -> all outputs 0 before the next edge; a fresh 12/8 run then yields d_o=4.
